// File: rtl/strided_read_driver_if.sv
// Signal bundle for strided_read_driver: job control, memory read port and output stream.
// The slave modport is the driver's view; master is the view of whoever drives it.
interface strided_read_driver_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  logic              i_START;
  logic              i_STOP;
  logic              i_MODE;
  logic [ADDR_W-1:0] i_BASE;
  logic [ADDR_W-1:0] i_STRIDE;
  logic [ADDR_W-1:0] i_LENGTH;

  logic              o_MEM_RE;
  logic [ADDR_W-1:0] o_MEM_ADDR;
  logic [DATA_W-1:0] i_MEM_DATA;

  logic [DATA_W-1:0] o_DATA;
  logic              o_LAST;
  logic              o_VALID;
  logic              i_READY;

  logic              o_BUSY;
  logic              o_DONE;

  modport slave (
    input  i_START, i_STOP, i_MODE, i_BASE, i_STRIDE, i_LENGTH, i_MEM_DATA, i_READY,
    output o_MEM_RE, o_MEM_ADDR, o_DATA, o_LAST, o_VALID, o_BUSY, o_DONE
  );

  modport master (
    output i_START, i_STOP, i_MODE, i_BASE, i_STRIDE, i_LENGTH, i_MEM_DATA, i_READY,
    input  o_MEM_RE, o_MEM_ADDR, o_DATA, o_LAST, o_VALID, o_BUSY, o_DONE
  );

endinterface

// File: rtl/strided_read_driver.sv
// Strided memory read sequencer: issues BASE + k*STRIDE reads (one-shot or looping) and
// buffers the returned words in a credit-controlled first-word-fall-through FIFO.
module strided_read_driver #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  i_CLK,
  input logic                  i_RST,
  strided_read_driver_if.slave io_bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Job configuration, latched when a start is accepted.
  logic              r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_length;

  // Address generator: current address and index within the pass.
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_k;

  // In-flight pipeline: one valid bit and last tag per outstanding read.
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_last;
  logic [CNT_W-1:0]  r_inflight;

  // Output FIFO; each entry holds {last, data}.
  logic [DATA_W:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_start;
  logic              w_issue;
  logic              w_done;
  logic              w_credit;
  logic              w_is_last;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_drained;
  logic [CNT_W-1:0]  w_occ;
  logic [DATA_W:0]   w_head;

  // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign w_occ     = r_inflight + r_count;
  assign w_credit  = w_occ < CNT_W'(FIFO_DEPTH);
  assign w_is_last = r_k == (r_length - ADDR_W'(1));
  assign w_drained = (r_inflight == '0) && (r_count == '0);

  assign w_push  = r_pipe_vld[RD_LAT-1];
  assign w_valid = r_count != '0;
  assign w_pop   = w_valid & io_bus.i_READY;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      StIdle: begin
        if (io_bus.i_START) begin
          w_start     = 1'b1;
          w_state_nxt = (io_bus.i_LENGTH != '0) ? StIssue : StDrain;
        end
      end
      StIssue: begin
        // Stop takes priority over any read, including the final one of a pass.
        if (io_bus.i_STOP) begin
          w_state_nxt = StDrain;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if (w_is_last && !r_mode) begin
            w_state_nxt = StDrain;
          end
        end
      end
      StDrain: begin
        if (w_drained) begin
          w_done      = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_mode      <= 1'b0;
      r_base      <= '0;
      r_stride    <= '0;
      r_length    <= '0;
      r_addr      <= '0;
      r_k         <= '0;
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
      r_inflight  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_start) begin
        r_mode   <= io_bus.i_MODE;
        r_base   <= io_bus.i_BASE;
        r_stride <= io_bus.i_STRIDE;
        r_length <= io_bus.i_LENGTH;
        r_addr   <= io_bus.i_BASE;
        r_k      <= '0;
      end else if (w_issue) begin
        if (w_is_last) begin
          r_addr <= r_base;
          r_k    <= '0;
        end else begin
          r_addr <= r_addr + r_stride;
          r_k    <= r_k + ADDR_W'(1);
        end
      end

      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue & w_is_last;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_pipe_last[RD_LAT-1], io_bus.i_MEM_DATA};
    end
  end

  // Head fields are masked while empty so stale storage never shows on the outputs.
  assign io_bus.o_VALID    = w_valid;
  assign io_bus.o_DATA     = w_valid ? w_head[DATA_W-1:0] : '0;
  assign io_bus.o_LAST     = w_valid & w_head[DATA_W];
  assign io_bus.o_MEM_RE   = w_issue;
  assign io_bus.o_MEM_ADDR = w_issue ? r_addr : '0;
  assign io_bus.o_BUSY     = (r_state != StIdle) & ~w_done;
  assign io_bus.o_DONE     = w_done;

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge i_CLK) disable iff (i_RST)
    !(w_push && (r_count == CNT_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_strided_read_driver.sv
// Self-checking bench for strided_read_driver: random and directed jobs against a
// queue-based model of the address sequence, word stream and job completion.
module tb_strided_read_driver;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          NEVER      = 1 << 30;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  strided_read_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  strided_read_driver #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .io_bus(bus)
  );

  // Memory returns ~addr RD_LAT cycles after a read; garbage on non-read cycles.
  logic [DATA_W-1:0] mpipe [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= bus.o_MEM_RE ? ~bus.o_MEM_ADDR : 8'($urandom);
  end
  assign bus.i_MEM_DATA = mpipe[RD_LAT-1];

  always @(posedge clk) begin
    #1;
    bus.i_READY = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Model state
  bit    m_mode, m_active, m_stopped;
  int    m_base, m_stride, m_len, m_k, m_issued, m_popped;
  int    m_start_cyc, m_finish_cyc;
  word_t expq[$];

  // Logs for directed expectations
  int re_cyc[$], re_addr[$], pop_data[$], pop_last[$], pop_cyc[$], done_cyc[$], valid_cyc[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [7:0] ea;
    word_t      w;
    bit         done_exp;
    if (rst) begin
      expq.delete();
      m_active = 1'b0;
    end else begin
      done_exp = m_active && (cyc > m_finish_cyc) && (expq.size() == 0);
      check("done", bus.o_DONE, done_exp);
      check("busy", bus.o_BUSY, m_active && (cyc > m_start_cyc) && !done_exp);
      if (bus.i_STOP && m_active && cyc > m_start_cyc && cyc < m_finish_cyc) m_finish_cyc = cyc;

      if (bus.o_VALID) begin
        valid_cyc.push_back(cyc);
        check("valid_has_word", expq.size() > 0, 1);
        if (bus.i_READY && expq.size() > 0) begin
          w = expq.pop_front();
          check("pop_data", bus.o_DATA, w.d);
          check("pop_last", bus.o_LAST, w.l);
          pop_data.push_back(int'(bus.o_DATA));
          pop_last.push_back(int'(bus.o_LAST));
          pop_cyc.push_back(cyc);
          m_popped++;
        end
      end

      if (bus.o_MEM_RE) begin
        ea = 8'(m_base + m_k * m_stride);
        check("re_window", m_active && cyc > m_start_cyc && cyc <= m_finish_cyc, 1);
        check("re_not_on_stop", bus.i_STOP, 0);
        check("re_addr", bus.o_MEM_ADDR, ea);
        w.d = ~ea;
        w.l = (m_k == m_len - 1);
        expq.push_back(w);
        re_cyc.push_back(cyc);
        re_addr.push_back(int'(bus.o_MEM_ADDR));
        m_issued++;
        m_k = (m_k == m_len - 1) ? 0 : m_k + 1;
        if (!m_mode) begin
          check("oneshot_count", m_issued <= m_len, 1);
          if (m_issued == m_len) m_finish_cyc = cyc;
        end
        check("credit", (m_issued - m_popped) <= int'(FIFO_DEPTH), 1);
      end

      if (bus.o_DONE && m_active) begin
        done_cyc.push_back(cyc);
        if (!m_mode && !m_stopped) check("done_all_reads", m_issued, m_len);
        m_active = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    re_cyc.delete(); re_addr.delete(); pop_data.delete(); pop_last.delete();
    pop_cyc.delete(); done_cyc.delete(); valid_cyc.delete();
  endtask

  task automatic start_job(input bit mode, input int base, input int stride, input int len);
    @(posedge clk); #1;
    bus.i_START  = 1'b1;
    bus.i_MODE   = mode;
    bus.i_BASE   = 8'(base);
    bus.i_STRIDE = 8'(stride);
    bus.i_LENGTH = 8'(len);
    clear_logs();
    m_mode = mode; m_base = base; m_stride = stride; m_len = len;
    m_k = 0; m_issued = 0; m_popped = 0; m_stopped = 1'b0;
    m_start_cyc  = cyc;
    m_finish_cyc = (len == 0) ? cyc : NEVER;
    m_active     = 1'b1;
    @(posedge clk); #1;
    // Scramble config to show it was latched on the start cycle.
    bus.i_START  = 1'b0;
    bus.i_MODE   = 1'($urandom);
    bus.i_BASE   = 8'($urandom);
    bus.i_STRIDE = 8'($urandom);
    bus.i_LENGTH = 8'($urandom);
  endtask

  task automatic pulse_stop();
    bus.i_STOP = 1'b1;
    m_stopped  = 1'b1;
    @(posedge clk); #1;
    bus.i_STOP = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (m_active && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_timeout", m_active, 0);
  endtask

  task automatic check_outs_zero(input string name);
    check(name, {bus.o_MEM_RE, bus.o_MEM_ADDR, bus.o_DATA, bus.o_LAST, bus.o_VALID,
                 bus.o_BUSY, bus.o_DONE}, 0);
  endtask

  int exp_a1[4] = '{'h10, 'h11, 'h12, 'h13};
  int exp_d1[4] = '{'hEF, 'hEE, 'hED, 'hEC};
  int exp_l1[4] = '{0, 0, 0, 1};
  int exp_a2[3] = '{'hFC, 'hFF, 'h02};
  int exp_d2[3] = '{'h03, 'h00, 'hFD};
  int exp_a5[7] = '{0, 2, 4, 0, 2, 4, 0};
  int exp_l5[7] = '{0, 0, 1, 0, 0, 1, 0};
  int exp_a7[6] = '{'h80, 'h85, 'h8A, 'h8F, 'h94, 'h99};

  initial begin : stim
    bit md;
    int ln;
    bus.i_START = 0; bus.i_STOP = 0; bus.i_MODE = 0;
    bus.i_BASE = 0; bus.i_STRIDE = 0; bus.i_LENGTH = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outs_zero("reset_outputs");

    // One-shot, consecutive addresses
    rdy_mode = 0;
    start_job(0, 'h10, 1, 4);
    wait_done(50);
    check("t1_reads", re_addr.size(), 4);
    check("t1_words", pop_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", (i < re_addr.size()) ? re_addr[i] : -1, exp_a1[i]);
      check("t1_data", (i < pop_data.size()) ? pop_data[i] : -1, exp_d1[i]);
      check("t1_last", (i < pop_last.size()) ? pop_last[i] : -1, exp_l1[i]);
    end
    check("t1_first_re", (re_cyc.size() > 0) ? re_cyc[0] : -1, m_start_cyc + 1);
    check("t1_back_to_back", (re_cyc.size() == 4) ? re_cyc[3] - re_cyc[0] : -1, 3);
    check("t1_latency", (valid_cyc.size() > 0 && re_cyc.size() > 0) ?
          valid_cyc[0] - re_cyc[0] : -1, RD_LAT + 1);
    check("t1_throughput", (pop_cyc.size() == 4) ? pop_cyc[3] - pop_cyc[0] : -1, 3);
    check("t1_done_cycle", (done_cyc.size() > 0 && pop_cyc.size() == 4) ?
          done_cyc[0] - pop_cyc[3] : -1, 1);

    // Address wrap with stride
    start_job(0, 'hFC, 3, 3);
    wait_done(50);
    check("t2_reads", re_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_addr", (i < re_addr.size()) ? re_addr[i] : -1, exp_a2[i]);
      check("t2_data", (i < pop_data.size()) ? pop_data[i] : -1, exp_d2[i]);
    end

    // Backpressure: credit limits issue to FIFO_DEPTH reads
    rdy_mode = 2;
    start_job(0, 'h40, 1, 10);
    repeat (20) @(posedge clk);
    #1 check("t3_reads_stalled", re_addr.size(), FIFO_DEPTH);
    rdy_mode = 0;
    wait_done(100);
    check("t3_words", pop_data.size(), 10);

    // Continuous loop, stopped 8 cycles after start
    start_job(1, 0, 2, 3);
    repeat (7) @(posedge clk);
    #1 pulse_stop();
    wait_done(50);
    check("t4_reads", re_addr.size(), 7);
    check("t4_words", pop_data.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check("t4_addr", (i < re_addr.size()) ? re_addr[i] : -1, exp_a5[i]);
      check("t4_last", (i < pop_last.size()) ? pop_last[i] : -1, exp_l5[i]);
    end

    // Empty job
    start_job(0, 'h33, 1, 0);
    wait_done(10);
    check("t5_no_reads", re_addr.size(), 0);
    check("t5_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, m_start_cyc + 1);

    // Start while busy is ignored
    rdy_mode = 1;
    start_job(0, 'h80, 5, 6);
    @(posedge clk); #1;
    bus.i_START = 1; bus.i_MODE = 1; bus.i_BASE = 0; bus.i_LENGTH = 2;
    @(posedge clk); #1;
    bus.i_START = 0;
    wait_done(100);
    check("t6_reads", re_addr.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t6_addr", (i < re_addr.size()) ? re_addr[i] : -1, exp_a7[i]);
    repeat (3) @(posedge clk);

    // Reset mid-job
    rdy_mode = 2;
    start_job(0, 'h20, 1, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_active = 1'b0;
    @(negedge clk);
    check_outs_zero("t7_reset_outputs");
    clear_logs();
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t7_no_stale_valid", valid_cyc.size(), 0);
    check("t7_no_done", done_cyc.size(), 0);

    // Randomized jobs
    for (int j = 0; j < 14; j++) begin
      md = ($urandom_range(0, 2) == 0);
      ln = md ? $urandom_range(1, 5) : $urandom_range(1, 12);
      rdy_mode = 1;
      start_job(md, $urandom_range(0, 255), $urandom_range(0, 255), ln);
      if (md) begin
        repeat ($urandom_range(5, 25)) @(posedge clk);
        #1 pulse_stop();
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, ln)) @(posedge clk);
        #1 pulse_stop();
      end
      wait_done(500);
      repeat (2) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
